// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store initiator for a word-organised, byte-selectable RAM.
// Optional MEM_ALIGN_EXC_EN: flag misaligned half/word accesses and skip the RAM cycle.
`default_nettype none

module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic [2:0]        op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              done_o,
    output logic              stallreq_o,
    output logic              align_err_o,
    output logic              mem_ce_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_sel_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i
);

    localparam logic [2:0] c_OP_LB  = 3'b000;
    localparam logic [2:0] c_OP_LBU = 3'b001;
    localparam logic [2:0] c_OP_LH  = 3'b010;
    localparam logic [2:0] c_OP_LHU = 3'b011;
    localparam logic [2:0] c_OP_LW  = 3'b100;
    localparam logic [2:0] c_OP_SB  = 3'b101;
    localparam logic [2:0] c_OP_SH  = 3'b110;
    localparam logic [2:0] c_OP_SW  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t            r_state;
    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_rdata;
    logic              r_done;
    logic              r_ce;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_sel;
    logic [DATA_W-1:0] r_data;

    logic              w_is_store;
    logic              w_misalign;
    logic [3:0]        w_sel;
    logic [DATA_W-1:0] w_wdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_load;

    assign w_is_store = (op_i == c_OP_SB) || (op_i == c_OP_SH) || (op_i == c_OP_SW);

`ifdef MEM_ALIGN_EXC_EN
    logic r_align_err;
    assign w_misalign = (((op_i == c_OP_LH) || (op_i == c_OP_LHU) || (op_i == c_OP_SH)) && addr_i[0])
                     || (((op_i == c_OP_LW) || (op_i == c_OP_SW)) && (addr_i[1:0] != 2'b00));
    assign align_err_o = r_align_err;
`else
    assign w_misalign  = 1'b0;
    assign align_err_o = 1'b0;
`endif

    // Big-endian lanes: lowest byte address maps to data[31:24].
    always_comb begin
        w_sel   = 4'b1111;
        w_wdata = wdata_i;
        case (op_i)
            c_OP_LB, c_OP_LBU, c_OP_SB: begin
                w_sel   = 4'b1000 >> addr_i[1:0];
                w_wdata = {4{wdata_i[7:0]}};
            end
            c_OP_LH, c_OP_LHU, c_OP_SH: begin
                w_sel   = addr_i[1] ? 4'b0011 : 4'b1100;
                w_wdata = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = 8'h00;
        case (r_addr[1:0])
            2'b00:   w_byte = mem_data_i[31:24];
            2'b01:   w_byte = mem_data_i[23:16];
            2'b10:   w_byte = mem_data_i[15:8];
            default: w_byte = mem_data_i[7:0];
        endcase
        w_half = r_addr[1] ? mem_data_i[15:0] : mem_data_i[31:16];
        case (r_op)
            c_OP_LB:  w_load = {{24{w_byte[7]}}, w_byte};
            c_OP_LBU: w_load = {24'h0, w_byte};
            c_OP_LH:  w_load = {{16{w_half[15]}}, w_half};
            c_OP_LHU: w_load = {16'h0, w_half};
            default:  w_load = mem_data_i;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_rdata <= '0;
            r_done  <= 1'b0;
            r_ce    <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_sel   <= '0;
            r_data  <= '0;
`ifdef MEM_ALIGN_EXC_EN
            r_align_err <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_i) begin
                        r_op <= op_i;
                        if (w_misalign) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_rdata <= '0;
`ifdef MEM_ALIGN_EXC_EN
                            r_align_err <= 1'b1;
`endif
                        end else begin
                            r_state <= S_ACCESS;
                            r_ce    <= 1'b1;
                            r_we    <= w_is_store;
                            r_addr  <= addr_i;
                            r_sel   <= w_sel;
                            r_data  <= w_is_store ? w_wdata : '0;
                        end
                    end
                end
                S_ACCESS: begin
                    // The RAM commits a store on this same edge; loads capture here.
                    if (!r_we) begin
                        r_rdata <= w_load;
                    end
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                    r_ce    <= 1'b0;
                    r_we    <= 1'b0;
                    r_addr  <= '0;
                    r_sel   <= '0;
                    r_data  <= '0;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
`ifdef MEM_ALIGN_EXC_EN
                    r_align_err <= 1'b0;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stallreq_o = ((r_state == S_IDLE) && req_i) || (r_state == S_ACCESS);
    assign rdata_o    = r_rdata;
    assign done_o     = r_done;
    assign mem_ce_o   = r_ce;
    assign mem_we_o   = r_we;
    assign mem_addr_o = r_addr;
    assign mem_sel_o  = r_sel;
    assign mem_data_o = r_data;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: byte-lane RAM model plus load-result scoreboard.
`default_nettype none

module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req_i;
    logic [2:0]  op_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        done_o;
    logic        stallreq_o;
    logic        align_err_o;
    logic        mem_ce_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;

    int          vecs = 0;
    int          errs = 0;
    logic [31:0] sb[$];
    logic [31:0] last_rd;
    logic        ram_clr;
    logic [31:0] ram [0:63];

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .op_i       (op_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .rdata_o    (rdata_o),
        .done_o     (done_o),
        .stallreq_o (stallreq_o),
        .align_err_o(align_err_o),
        .mem_ce_o   (mem_ce_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_sel_o  (mem_sel_o),
        .mem_data_o (mem_data_o),
        .mem_data_i (mem_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
        end else if (mem_ce_o && mem_we_o) begin
            for (int b = 0; b < 4; b++)
                if (mem_sel_o[b]) ram[mem_addr_o[7:2]][b*8 +: 8] <= mem_data_o[b*8 +: 8];
        end
    end
    assign mem_data_i = ram[mem_addr_o[7:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        req_i = 1'b0;
        #1;
        chk("idle_done", {31'b0, done_o}, 32'h0);
        chk("idle_stall", {31'b0, stallreq_o}, 32'h0);
    endtask

    // Cycle 0 presents the request, cycle 1 is the RAM access, cycle 2 is done.
    task automatic access(input string nm, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] exp_sel,
                          input logic [31:0] exp_mdata, input logic [31:0] exp_rd);
        logic        st;
        logic [31:0] e;
        st = (op >= 3'b101);
        @(negedge clk);
        req_i = 1'b1; op_i = op; addr_i = addr; wdata_i = wd;
        if (!st) sb.push_back(exp_rd);
        #1;
        chk({nm, ".stall0"}, {31'b0, stallreq_o}, 32'h1);
        chk({nm, ".ce0"}, {31'b0, mem_ce_o}, 32'h0);
        @(negedge clk);
        chk({nm, ".ce1"}, {31'b0, mem_ce_o}, 32'h1);
        chk({nm, ".we1"}, {31'b0, mem_we_o}, {31'b0, st});
        chk({nm, ".sel1"}, {28'b0, mem_sel_o}, {28'b0, exp_sel});
        chk({nm, ".addr1"}, mem_addr_o, addr);
        if (st) chk({nm, ".data1"}, mem_data_o, exp_mdata);
        chk({nm, ".stall1"}, {31'b0, stallreq_o}, 32'h1);
        chk({nm, ".done1"}, {31'b0, done_o}, 32'h0);
        @(negedge clk);
        chk({nm, ".done2"}, {31'b0, done_o}, 32'h1);
        chk({nm, ".stall2"}, {31'b0, stallreq_o}, 32'h0);
        chk({nm, ".ce2"}, {31'b0, mem_ce_o}, 32'h0);
        chk({nm, ".sel2"}, {28'b0, mem_sel_o}, 32'h0);
        chk({nm, ".aerr2"}, {31'b0, align_err_o}, 32'h0);
        if (!st) begin
            if (sb.size() == 0) begin
                vecs++; errs++;
                $error("FAIL %s.sb: observed empty scoreboard expected entry", nm);
            end else begin
                e = sb.pop_front();
                chk({nm, ".rdata"}, rdata_o, e);
                last_rd = e;
            end
        end else begin
            chk({nm, ".rdata_hold"}, rdata_o, last_rd);
        end
    endtask

    initial begin
        rst = 1'b0; req_i = 1'b0; op_i = 3'b000; addr_i = 32'h0; wdata_i = 32'h0;
        ram_clr = 1'b1; last_rd = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_ce", {31'b0, mem_ce_o}, 32'h0);
        chk("rst_we", {31'b0, mem_we_o}, 32'h0);
        chk("rst_done", {31'b0, done_o}, 32'h0);
        chk("rst_stall", {31'b0, stallreq_o}, 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_sel", {28'b0, mem_sel_o}, 32'h0);
        rst = 1'b1; ram_clr = 1'b0;

        access("sw10",  3'b111, 32'h10, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'h0);
        idle();
        access("lw10",  3'b100, 32'h10, 32'h0, 4'b1111, 32'h0, 32'hDEADBEEF);
        idle();
        access("sb13",  3'b101, 32'h13, 32'h000000A5, 4'b0001, 32'hA5A5A5A5, 32'h0);
        access("lb13",  3'b000, 32'h13, 32'h0, 4'b0001, 32'h0, 32'hFFFFFFA5);
        access("lbu13", 3'b001, 32'h13, 32'h0, 4'b0001, 32'h0, 32'h000000A5);
        access("sb10",  3'b101, 32'h10, 32'h0000007F, 4'b1000, 32'h7F7F7F7F, 32'h0);
        access("lb10",  3'b000, 32'h10, 32'h0, 4'b1000, 32'h0, 32'h0000007F);
        idle();
        access("sh22",  3'b110, 32'h22, 32'h00008001, 4'b0011, 32'h80018001, 32'h0);
        access("lh22",  3'b010, 32'h22, 32'h0, 4'b0011, 32'h0, 32'hFFFF8001);
        access("lhu22", 3'b011, 32'h22, 32'h0, 4'b0011, 32'h0, 32'h00008001);
        access("lh20",  3'b010, 32'h20, 32'h0, 4'b1100, 32'h0, 32'h00000000);
        idle();
        // Back-to-back: request held, next op presented right after done.
        access("b2b_lw", 3'b100, 32'h10, 32'h0, 4'b1111, 32'h0, 32'h7FADBEA5);
        access("b2b_sw", 3'b111, 32'h14, 32'h01020304, 4'b1111, 32'h01020304, 32'h0);
        access("lw14",   3'b100, 32'h14, 32'h0, 4'b1111, 32'h0, 32'h01020304);
        idle();

`ifdef MEM_ALIGN_EXC_EN
        @(negedge clk);
        req_i = 1'b1; op_i = 3'b100; addr_i = 32'h11; wdata_i = 32'h0;
        #1;
        chk("mis.stall0", {31'b0, stallreq_o}, 32'h1);
        @(negedge clk);
        chk("mis.ce", {31'b0, mem_ce_o}, 32'h0);
        chk("mis.done", {31'b0, done_o}, 32'h1);
        chk("mis.aerr", {31'b0, align_err_o}, 32'h1);
        chk("mis.rdata", rdata_o, 32'h0);
        last_rd = 32'h0;
        idle();
`else
        access("lw11", 3'b100, 32'h11, 32'h0, 4'b1111, 32'h0, 32'h7FADBEA5);
        idle();
`endif

        // Reset in the middle of a store access.
        @(negedge clk);
        req_i = 1'b1; op_i = 3'b111; addr_i = 32'h30; wdata_i = 32'h12345678;
        @(negedge clk);
        chk("rstmid.we_pre", {31'b0, mem_we_o}, 32'h1);
        #2;
        rst = 1'b0; req_i = 1'b0;
        #1;
        chk("rstmid.we", {31'b0, mem_we_o}, 32'h0);
        chk("rstmid.ce", {31'b0, mem_ce_o}, 32'h0);
        chk("rstmid.sel", {28'b0, mem_sel_o}, 32'h0);
        chk("rstmid.data", mem_data_o, 32'h0);
        chk("rstmid.addr", mem_addr_o, 32'h0);
        chk("rstmid.rdata", rdata_o, 32'h0);
        chk("rstmid.stall", {31'b0, stallreq_o}, 32'h0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rstmid.done", {31'b0, done_o}, 32'h0);
        end
        rst = 1'b1; last_rd = 32'h0;
        idle();
        access("lw30", 3'b100, 32'h30, 32'h0, 4'b1111, 32'h0, 32'h00000000);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

`default_nettype wire
